// File: rtl/seq_pattern_tx_pkg.sv
// Shared definitions for the seq_pattern_tx / seq_detector pair.
// Holds the transmitter state encoding and the default pattern constants.
package seq_pkg;

  localparam int SEQ_PAT_W = 4;
  localparam logic [SEQ_PAT_W-1:0] SEQ_PAT_DEFAULT = 4'b1101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } tx_state_t;

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Start handshake bundle for seq_pattern_tx: request valid/ready plus the
// pattern, repeat count and gap fields captured on acceptance.
interface seq_pattern_tx_if #(
  parameter int PAT_W = 4,
  parameter int REP_W = 4,
  parameter int GAP_W = 4
) ();
  logic             start_valid;
  logic             start_ready;
  logic [PAT_W-1:0] pattern_in;
  logic [REP_W-1:0] rep_in;
  logic [GAP_W-1:0] gap_in;

  modport master (output start_valid, pattern_in, rep_in, gap_in,
                  input  start_ready);
  modport slave  (input  start_valid, pattern_in, rep_in, gap_in,
                  output start_ready);
endinterface

// File: rtl/seq_pattern_tx_shifter.sv
// seq_tx_shifter: pattern register and bit index for seq_pattern_tx.
// Presents the bit that goes on the line at the next edge (next_bit), the
// pattern MSB for restarts out of a gap, and a flag for the final bit.
module seq_tx_shifter #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [PAT_W-1:0] pattern_d,
  output logic             next_bit,
  output logic             msb_bit,
  output logic             last_bit
);
  localparam int IDX_W = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

  logic [PAT_W-1:0] pat_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_m1;

  // Capture on load; on shift step down, wrapping to the MSB after the last
  // bit so back-to-back repetitions need no separate reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q <= '0;
      idx_q <= IDX_TOP;
    end else if (load) begin
      pat_q <= pattern_d;
      idx_q <= IDX_TOP;
    end else if (shift) begin
      idx_q <= last_bit ? IDX_TOP : idx_q - 1'b1;
    end
  end

  assign last_bit = (idx_q == '0);
  assign idx_m1   = idx_q - 1'b1;
  assign msb_bit  = pat_q[PAT_W-1];
  assign next_bit = last_bit ? pat_q[PAT_W-1] : pat_q[idx_m1];
endmodule

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial pattern transmitter feeding seq_detector.seq_in.
// Sends a captured pattern MSB-first, (rep+1) times, with gap idle cycles
// between repetitions. Optional macro SEQ_TX_EXPECT_EN adds expect_detect,
// a pulse marking the cycle a Moore detector should flag each repetition.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int   PAT_W      = 4,
  parameter int   REP_W      = 4,
  parameter int   GAP_W      = 4,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  seq_pattern_tx_if.slave        req,
  input  logic                   abort,
  output logic                   seq_out,
  output logic                   busy,
  output logic                   done
`ifdef SEQ_TX_EXPECT_EN
  ,output logic                  expect_detect
`endif
);
  tx_state_t        state;
  logic [REP_W-1:0] rep_q, rep_cnt;
  logic [GAP_W-1:0] gap_q, gap_cnt;
  logic             accept, sh_load, sh_shift;
  logic             next_bit, msb_bit, last_bit;

  // abort wins over a simultaneous start
  assign req.start_ready = (state == IDLE);
  assign accept          = (state == IDLE) && req.start_valid && !abort;
  assign sh_load         = accept;
  assign sh_shift        = (state == SHIFT) && !abort;

  seq_tx_shifter #(.PAT_W(PAT_W)) u_shifter (
    .clk       (clk),
    .rst_n     (reset),
    .load      (sh_load),
    .shift     (sh_shift),
    .pattern_d (req.pattern_in),
    .next_bit  (next_bit),
    .msb_bit   (msb_bit),
    .last_bit  (last_bit)
  );

  // Control FSM; seq_out/busy/done are registered alongside the state so the
  // first pattern bit appears on the accept edge itself.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      rep_q   <= '0;
      gap_q   <= '0;
      rep_cnt <= '0;
      gap_cnt <= '0;
      seq_out <= IDLE_LEVEL;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            rep_q   <= req.rep_in;
            gap_q   <= req.gap_in;
            rep_cnt <= '0;
            state   <= SHIFT;
            seq_out <= req.pattern_in[PAT_W-1];
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          if (abort) begin
            state   <= IDLE;
            seq_out <= IDLE_LEVEL;
            busy    <= 1'b0;
          end else if (last_bit) begin
            if (rep_cnt == rep_q) begin
              state   <= IDLE;
              seq_out <= IDLE_LEVEL;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else if (gap_q != '0) begin
              state   <= GAP;
              gap_cnt <= gap_q - 1'b1;
              seq_out <= IDLE_LEVEL;
            end else begin
              rep_cnt <= rep_cnt + 1'b1;
              seq_out <= next_bit;
            end
          end else begin
            seq_out <= next_bit;
          end
        end
        GAP: begin
          if (abort) begin
            state   <= IDLE;
            seq_out <= IDLE_LEVEL;
            busy    <= 1'b0;
          end else if (gap_cnt == '0) begin
            state   <= SHIFT;
            rep_cnt <= rep_cnt + 1'b1;
            seq_out <= msb_bit;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          seq_out <= IDLE_LEVEL;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef SEQ_TX_EXPECT_EN
  // Pulse one cycle after each repetition's final bit has been on the line
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) expect_detect <= 1'b0;
    else        expect_detect <= (state == SHIFT) && last_bit;
  end
`endif
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: stimulus pushes hand-written expected
// line tokens ('1'/'0' pattern bit, 'g' gap cycle, 'D' done cycle) and a
// negedge monitor pops one token per busy/done cycle.
module tb_seq_pattern_tx;
  import seq_pkg::*;

  localparam int   PAT_W = 4;
  localparam int   REP_W = 4;
  localparam int   GAP_W = 4;
  localparam logic IDLE_LEVEL = 1'b0;

  logic clk = 1'b0;
  logic reset;
  logic abort;
  logic seq_out, busy, done;
`ifdef SEQ_TX_EXPECT_EN
  logic expect_detect;
  int   n_exp_pulses = 0;
  int   n_seen_pulses = 0;
`endif

  always #5 clk = ~clk;

  seq_pattern_tx_if #(.PAT_W(PAT_W), .REP_W(REP_W), .GAP_W(GAP_W)) tx_if ();

  seq_pattern_tx #(
    .PAT_W(PAT_W), .REP_W(REP_W), .GAP_W(GAP_W), .IDLE_LEVEL(IDLE_LEVEL)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (tx_if),
    .abort   (abort),
    .seq_out (seq_out),
    .busy    (busy),
    .done    (done)
`ifdef SEQ_TX_EXPECT_EN
    ,.expect_detect (expect_detect)
`endif
  );

  byte exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  // Monitor: one token per cycle where the DUT is busy or signalling done
  always @(negedge clk) begin
    byte c;
    if (reset === 1'b1) begin
      chk("start_ready", {31'd0, tx_if.start_ready}, {31'd0, !busy});
`ifdef SEQ_TX_EXPECT_EN
      if (expect_detect === 1'b1) n_seen_pulses++;
`endif
      if (busy === 1'b1 || done === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: busy=%b done=%b seq_out=%b with no token at %0t",
                   busy, done, seq_out, $time);
        end else begin
          c = exp_q.pop_front();
          chk($sformatf("line_token_%s", string'(c)), {29'd0, busy, done, seq_out},
              {29'd0, (c != "D"), (c == "D"), (c == "1")});
        end
      end else begin
        chk("idle_level", {31'd0, seq_out}, {31'd0, IDLE_LEVEL});
      end
    end
  end

  task automatic send(input logic [PAT_W-1:0] pat, input logic [REP_W-1:0] rep,
                      input logic [GAP_W-1:0] gap, input string exp, input int npulse);
    push(exp);
`ifdef SEQ_TX_EXPECT_EN
    n_exp_pulses += npulse;
`else
    if (npulse < 0) $display("negative pulse count");
`endif
    @(posedge clk); #1;
    tx_if.start_valid = 1'b1;
    tx_if.pattern_in  = pat;
    tx_if.rep_in      = rep;
    tx_if.gap_in      = gap;
    @(posedge clk); #1;
    tx_if.start_valid = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    bit ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
      @(posedge clk);
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d tokens left expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    abort = 1'b0;
    tx_if.start_valid = 1'b0;
    tx_if.pattern_in  = '0;
    tx_if.rep_in      = '0;
    tx_if.gap_in      = '0;
    #1;
    chk("reset_seq_out", {31'd0, seq_out}, 32'd0);
    chk("reset_busy",    {31'd0, busy},    32'd0);
    chk("reset_done",    {31'd0, done},    32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);

    // T1 single repetition
    send(SEQ_PAT_DEFAULT, 4'd0, 4'd0, "1101D", 1);
    drain(40);
    // T2 three back-to-back repetitions
    send(4'b1101, 4'd2, 4'd0, "110111011101D", 3);
    drain(60);
    // T3 two repetitions separated by a 3-cycle gap
    send(4'b1101, 4'd1, 4'd3, "1101ggg1101D", 2);
    drain(60);
    // leading zero bit and a single-cycle gap
    send(4'b0110, 4'd0, 4'd0, "0110D", 1);
    drain(40);
    send(4'b1000, 4'd1, 4'd1, "1000g1000D", 2);
    drain(60);

    // T4 abort on the 3rd bit, then abort+start together is refused
    send(4'b1101, 4'd2, 4'd0, "110", 0);
    @(posedge clk);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    tx_if.start_valid = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    tx_if.start_valid = 1'b0;
    abort = 1'b0;
    drain(20);

    // T5 start held across done; fields changed while busy must be ignored
    push("1101D1010D");
`ifdef SEQ_TX_EXPECT_EN
    n_exp_pulses += 2;
`endif
    @(posedge clk); #1;
    tx_if.start_valid = 1'b1;
    tx_if.pattern_in  = 4'b1101;
    tx_if.rep_in      = 4'd0;
    tx_if.gap_in      = 4'd0;
    @(posedge clk); #1;
    tx_if.pattern_in  = 4'b1010;
    tx_if.rep_in      = 4'd0;
    tx_if.gap_in      = 4'd5;
    repeat (5) @(posedge clk);
    #1 tx_if.start_valid = 1'b0;
    drain(40);

    // T5 reset pulled low mid-SHIFT
    push("1");
    @(posedge clk); #1;
    tx_if.start_valid = 1'b1;
    tx_if.pattern_in  = 4'b1111;
    tx_if.rep_in      = 4'd3;
    tx_if.gap_in      = 4'd0;
    @(posedge clk); #1;
    tx_if.start_valid = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("midreset_seq_out", {31'd0, seq_out}, 32'd0);
    chk("midreset_busy",    {31'd0, busy},    32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    drain(10);

    chk("queue_empty", exp_q.size(), 32'd0);
`ifdef SEQ_TX_EXPECT_EN
    chk("expect_pulses", n_seen_pulses, n_exp_pulses);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
